// File: rtl/montador_pixel_pkg.sv
// Shared definitions for the camera pixel assembly path: byte width, the RGB565 pixel
// width, the byte-order encoding and a constant clog2 for sizing counters.
package pixel_pkg;

    localparam int BYTE_W_DEFAULT = 8;
    localparam int RGB565_W       = 16;

    typedef enum logic {
        BYTE_ORDER_MSB_FIRST = 1'b0,
        BYTE_ORDER_LSB_FIRST = 1'b1
    } byte_order_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/montador_pixel_if.sv
// Byte-in / pixel-out bundle between the camera byte source and the pixel consumer.
interface montador_pixel_if
    import pixel_pkg::*;
#(
    parameter int BYTE_W          = BYTE_W_DEFAULT,
    parameter int BYTES_PER_PIXEL = 2,
    parameter int FIFO_DEPTH      = 4
);
    localparam int PIX_W = BYTE_W * BYTES_PER_PIXEL;
    localparam int IDX_W = clog2(BYTES_PER_PIXEL) + 1;
    localparam int CNT_W = clog2(FIFO_DEPTH) + 1;

    logic              enable;
    logic [BYTE_W-1:0] D;
    logic              swap;
    logic              flush;
    logic              pixel_ready;
    logic [PIX_W-1:0]  Q;
    logic              pixel_valid;
    logic [IDX_W-1:0]  byte_idx;
    logic [CNT_W-1:0]  fifo_count;
    logic              full;
    logic              overflow;

    modport master (
        output enable, D, swap, flush, pixel_ready,
        input  Q, pixel_valid, byte_idx, fifo_count, full, overflow
    );

    modport slave (
        input  enable, D, swap, flush, pixel_ready,
        output Q, pixel_valid, byte_idx, fifo_count, full, overflow
    );

endinterface

// File: rtl/montador_pixel_fifo.sv
// Synchronous FIFO whose head entry is held in a register, so dout keeps the last
// popped value while the FIFO is empty.
module fifo_pixel
    import pixel_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    clear,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic [clog2(DEPTH):0]   count,
    output logic                    full,
    output logic                    empty
);
    localparam int AW    = clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    rd_next;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = dout_q;

    // A push into a full FIFO is accepted only when a pop frees the head slot on the same edge.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rd_next = rd_ptr_q + 1'b1;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_next;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // The head register tracks whatever entry will sit at the read pointer after this edge.
        if (pop_ok) begin
            if (count_q == CNT_W'(1)) begin
                if (push_ok) dout_d = din;
            end else begin
                dout_d = mem_q[rd_next];
            end
        end else if (push_ok && empty) begin
            dout_d = din;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/montador_pixel.sv
// Assembles camera bytes into BYTES_PER_PIXEL-byte pixels with per-pixel byte order,
// partial-pixel flush and a buffered valid/ready output with sticky overflow.
module montador_pixel
    import pixel_pkg::*;
#(
    parameter int BYTE_W          = BYTE_W_DEFAULT,
    parameter int BYTES_PER_PIXEL = 2,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic             clock,
    input  logic             clear,
    montador_pixel_if.slave  bus
);
    localparam int PIX_W = BYTE_W * BYTES_PER_PIXEL;
    localparam int IDX_W = clog2(BYTES_PER_PIXEL) + 1;
    localparam int CNT_W = clog2(FIFO_DEPTH) + 1;

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [PIX_W-1:0] asm_q, asm_d;
    byte_order_e      swap_q, swap_d;
    logic             ovf_q, ovf_d;

    byte_order_e      ord;
    logic [PIX_W-1:0] pix;
    logic             push, pop;
    logic [PIX_W-1:0] fifo_dout;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_full, fifo_empty;

    assign pop = bus.pixel_ready && !fifo_empty;

    always_comb begin
        idx_d  = idx_q;
        asm_d  = asm_q;
        swap_d = swap_q;
        ovf_d  = ovf_q;
        push   = 1'b0;
        pix    = asm_q;
        // The first byte of a pixel uses the live swap input; later bytes use the latched order.
        ord    = (idx_q == '0) ? byte_order_e'(bus.swap) : swap_q;
        for (int k = 0; k < BYTES_PER_PIXEL; k++) begin
            if (idx_q == IDX_W'(k)) begin
                if (ord == BYTE_ORDER_LSB_FIRST) pix[k*BYTE_W +: BYTE_W] = bus.D;
                else                             pix[(BYTES_PER_PIXEL-1-k)*BYTE_W +: BYTE_W] = bus.D;
            end
        end
        if (bus.flush) begin
            idx_d = '0;
            asm_d = '0;
        end else if (bus.enable) begin
            if (idx_q == '0) swap_d = ord;
            if (idx_q == IDX_W'(BYTES_PER_PIXEL - 1)) begin
                push  = 1'b1;
                idx_d = '0;
                asm_d = '0;
            end else begin
                asm_d = pix;
                idx_d = idx_q + 1'b1;
            end
        end
        if (push && fifo_full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            idx_q  <= '0;
            asm_q  <= '0;
            swap_q <= BYTE_ORDER_MSB_FIRST;
            ovf_q  <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            asm_q  <= asm_d;
            swap_q <= swap_d;
            ovf_q  <= ovf_d;
        end
    end

    fifo_pixel #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .clear (clear),
        .push  (push),
        .pop   (pop),
        .din   (pix),
        .dout  (fifo_dout),
        .count (fifo_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.Q           = fifo_dout;
    assign bus.pixel_valid = !fifo_empty;
    assign bus.byte_idx    = idx_q;
    assign bus.fifo_count  = fifo_cnt;
    assign bus.full        = fifo_full;
    assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_montador_pixel.sv
// Directed bench for montador_pixel with 8-bit bytes, 2 bytes per pixel, 4-deep FIFO.
module tb_montador_pixel;

    logic clk = 1'b0;
    logic clr;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    montador_pixel_if #(.BYTE_W(8), .BYTES_PER_PIXEL(2), .FIFO_DEPTH(4)) bus ();

    montador_pixel #(.BYTE_W(8), .BYTES_PER_PIXEL(2), .FIFO_DEPTH(4)) dut (
        .clock (clk),
        .clear (clr),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.enable = 1'b1;
        bus.D      = b;
        tick();
        bus.enable = 1'b0;
    endtask

    task automatic send_pixel(input logic [15:0] p);
        send_byte(p[15:8]);
        send_byte(p[7:0]);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_Q"},     32'(bus.Q), 32'h0);
        check({tag, "_valid"}, 32'(bus.pixel_valid), 32'h0);
        check({tag, "_idx"},   32'(bus.byte_idx), 32'h0);
        check({tag, "_count"}, 32'(bus.fifo_count), 32'h0);
        check({tag, "_full"},  32'(bus.full), 32'h0);
        check({tag, "_ovf"},   32'(bus.overflow), 32'h0);
    endtask

    initial begin
        bus.enable = 1'b0; bus.D = '0; bus.swap = 1'b0; bus.flush = 1'b0; bus.pixel_ready = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (5) tick();
        check_cleared("reset");

        // Basic MSB-first pixel, latency and pop
        bus.swap = 1'b0; bus.pixel_ready = 1'b1;
        send_byte(8'hAA);
        check("t2_idx1", 32'(bus.byte_idx), 32'd1);
        send_byte(8'hCC);
        check("t2_valid", 32'(bus.pixel_valid), 32'd1);
        check("t2_Q",     32'(bus.Q), 32'hAACC);
        check("t2_idx0",  32'(bus.byte_idx), 32'd0);
        tick();
        check("t2_count", 32'(bus.fifo_count), 32'd0);
        check("t2_empty", 32'(bus.pixel_valid), 32'd0);
        check("t2_hold",  32'(bus.Q), 32'hAACC);

        // LSB-first and swap latched at the first byte
        bus.swap = 1'b1;
        send_byte(8'hF0);
        send_byte(8'h0F);
        check("t3_Q", 32'(bus.Q), 32'h0FF0);
        send_byte(8'h12);
        bus.swap = 1'b0;
        send_byte(8'h34);
        check("t3_latch", 32'(bus.Q), 32'h3412);
        check("t3_count", 32'(bus.fifo_count), 32'd1);
        tick();
        check("t3_drain", 32'(bus.fifo_count), 32'd0);

        // Fill, overflow, drain in order
        bus.pixel_ready = 1'b0;
        send_pixel(16'h1111); send_pixel(16'h2222); send_pixel(16'h3333); send_pixel(16'h4444);
        check("t4_full",   32'(bus.full), 32'd1);
        check("t4_noovf",  32'(bus.overflow), 32'd0);
        send_pixel(16'h5555);
        check("t4_ovf",    32'(bus.overflow), 32'd1);
        check("t4_count4", 32'(bus.fifo_count), 32'd4);
        check("t4_head",   32'(bus.Q), 32'h1111);
        bus.pixel_ready = 1'b1;
        tick(); check("t4_q2", 32'(bus.Q), 32'h2222);
        tick(); check("t4_q3", 32'(bus.Q), 32'h3333);
        tick(); check("t4_q4", 32'(bus.Q), 32'h4444);
        tick();
        check("t4_empty",  32'(bus.pixel_valid), 32'd0);
        check("t4_hold",   32'(bus.Q), 32'h4444);
        check("t4_sticky", 32'(bus.overflow), 32'd1);

        // Flush a partial pixel, then flush winning over enable
        bus.pixel_ready = 1'b0;
        send_byte(8'h12);
        check("t5_idx1", 32'(bus.byte_idx), 32'd1);
        bus.flush = 1'b1; tick(); bus.flush = 1'b0;
        check("t5_idx0", 32'(bus.byte_idx), 32'd0);
        send_byte(8'h34);
        send_byte(8'h56);
        check("t5_Q",     32'(bus.Q), 32'h3456);
        check("t5_count", 32'(bus.fifo_count), 32'd1);
        bus.flush = 1'b1;
        send_byte(8'h99);
        bus.flush = 1'b0;
        check("t5_flush_en", 32'(bus.byte_idx), 32'd0);
        check("t5_count1",   32'(bus.fifo_count), 32'd1);
        bus.pixel_ready = 1'b1;
        tick();
        check("t5_drain", 32'(bus.fifo_count), 32'd0);

        // Simultaneous push and pop while full
        clr = 1'b1; tick(); clr = 1'b0;
        bus.pixel_ready = 1'b0;
        send_pixel(16'h1010); send_pixel(16'h2020); send_pixel(16'h3030); send_pixel(16'h4040);
        send_byte(8'h77);
        bus.pixel_ready = 1'b1;
        send_byte(8'h77);
        bus.pixel_ready = 1'b0;
        check("t6_count", 32'(bus.fifo_count), 32'd4);
        check("t6_full",  32'(bus.full), 32'd1);
        check("t6_noovf", 32'(bus.overflow), 32'd0);
        check("t6_head",  32'(bus.Q), 32'h2020);
        bus.pixel_ready = 1'b1;
        tick(); check("t6_q3", 32'(bus.Q), 32'h3030);
        tick(); check("t6_q4", 32'(bus.Q), 32'h4040);
        tick(); check("t6_q7", 32'(bus.Q), 32'h7777);
        check("t6_valid", 32'(bus.pixel_valid), 32'd1);
        tick(); check("t6_empty", 32'(bus.pixel_valid), 32'd0);

        // Clear mid-pixel with data buffered
        bus.pixel_ready = 1'b0;
        send_pixel(16'h6666);
        send_byte(8'h55);
        check("t6_pre_idx", 32'(bus.byte_idx), 32'd1);
        clr = 1'b1; bus.enable = 1'b1; bus.D = 8'hEE; tick(); clr = 1'b0; bus.enable = 1'b0;
        check_cleared("t6_clear");
        send_pixel(16'hABCD);
        check("t6_after", 32'(bus.Q), 32'hABCD);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
